// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the mem_copy_mst block-copy initiator.
// Optional fill mode is enabled with MEM_COPY_FILL_EN.
package mem_copy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int C_ADDR_LEN = 8;
    localparam int C_DATA_LEN = 16;

    localparam logic [C_DATA_LEN-1:0] C_DATA_ONES = '1;
    localparam logic [C_DATA_LEN-1:0] C_DATA_ZERO = '0;

endpackage

// File: rtl/mem_copy_ctr.sv
// Loadable source/destination address and word-count stepper.
// Addresses wrap naturally at 2^CAddrLen.
module mem_copy_ctr
    import mem_copy_pkg::*;
#(
    parameter int CAddrLen = C_ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step_src,
    input  logic                step_dst,
    input  logic [CAddrLen-1:0] src_in,
    input  logic [CAddrLen-1:0] dst_in,
    input  logic [CAddrLen:0]   len_in,
    output logic [CAddrLen-1:0] src_o,
    output logic [CAddrLen-1:0] dst_o,
    output logic [CAddrLen:0]   left_o,
    output logic [CAddrLen:0]   cnt_o
);

    logic [CAddrLen-1:0] src_q, src_d;
    logic [CAddrLen-1:0] dst_q, dst_d;
    logic [CAddrLen:0]   left_q, left_d;
    logic [CAddrLen:0]   cnt_q, cnt_d;

    // load all counters on start, otherwise step on read/write beats
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        left_d = left_q;
        cnt_d  = cnt_q;
        if (load) begin
            src_d  = src_in;
            dst_d  = dst_in;
            left_d = len_in;
            cnt_d  = '0;
        end else begin
            if (step_src) begin
                src_d = src_q + 1'b1;
            end
            if (step_dst) begin
                dst_d  = dst_q + 1'b1;
                left_d = left_q - 1'b1;
                cnt_d  = cnt_q + 1'b1;
            end
        end
    end

    // counter registers, synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            left_q <= '0;
            cnt_q  <= '0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            left_q <= left_d;
            cnt_q  <= cnt_d;
        end
    end

    assign src_o  = src_q;
    assign dst_o  = dst_q;
    assign left_o = left_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/mem_copy_mst.sv
// RAM-port initiator copying a block of words inside one single-port RAM.
// Define MEM_COPY_FILL_EN to add AFill/AFillData constant-fill mode.
module mem_copy_mst
    import mem_copy_pkg::*;
#(
    parameter int CAddrLen = C_ADDR_LEN,
    parameter int CDataLen = C_DATA_LEN
) (
    input  logic                AClkH,
    input  logic                AResetN,
    input  logic                AClkHEn,
    input  logic                AStart,
    input  logic                AAbort,
    input  logic [CAddrLen-1:0] ASrc,
    input  logic [CAddrLen-1:0] ADst,
    input  logic [CAddrLen:0]   ALen,
`ifdef MEM_COPY_FILL_EN
    input  logic                AFill,
    input  logic [CDataLen-1:0] AFillData,
`endif
    output logic                ABusy,
    output logic                ADone,
    output logic [CAddrLen:0]   ACnt,
    output logic [CAddrLen-1:0] AAddr,
    output logic [CDataLen-1:0] AMosi,
    input  logic [CDataLen-1:0] AMiso,
    output logic [CDataLen-1:0] AWrEn,
    output logic                ARdEn
);

    state_e state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   fill_q, fill_d;
    logic   fill_req;
    logic [CDataLen-1:0] fill_data;

    logic                load, step_src, step_dst;
    logic [CAddrLen-1:0] src, dst;
    logic [CAddrLen:0]   left, cnt;
    logic                last_word;

`ifdef MEM_COPY_FILL_EN
    assign fill_req  = AFill;
    assign fill_data = AFillData;
`else
    assign fill_req  = 1'b0;
    assign fill_data = '0;
`endif

    assign last_word = (left == {{CAddrLen{1'b0}}, 1'b1});

    mem_copy_ctr #(
        .CAddrLen(CAddrLen)
    ) u_ctr (
        .clk     (AClkH),
        .rst_n   (AResetN),
        .load    (load),
        .step_src(step_src),
        .step_dst(step_dst),
        .src_in  (ASrc),
        .dst_in  (ADst),
        .len_in  (ALen),
        .src_o   (src),
        .dst_o   (dst),
        .left_o  (left),
        .cnt_o   (cnt)
    );

    // next-state, counter steps and next registered status outputs
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = done_q;
        fill_d   = fill_q;
        load     = 1'b0;
        step_src = 1'b0;
        step_dst = 1'b0;
        if (AClkHEn) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (AStart) begin
                        load   = 1'b1;
                        fill_d = fill_req;
                        if (ALen == '0) begin
                            state_d = ST_DONE;
                        end else if (fill_req) begin
                            state_d = ST_WR;
                        end else begin
                            state_d = ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    step_src = 1'b1;
                    state_d  = AAbort ? ST_DONE : ST_WR;
                end
                ST_WR: begin
                    step_dst = 1'b1;
                    if (AAbort || last_word) begin
                        state_d = ST_DONE;
                    end else if (fill_q) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
            endcase
            busy_d = (state_d != ST_IDLE);
            done_d = (state_d == ST_DONE);
        end
    end

    // FSM state and status registers
    always_ff @(posedge AClkH) begin
        if (!AResetN) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fill_q  <= fill_d;
        end
    end

    // RAM port decode from registered state; write data passes through
    always_comb begin
        AAddr = '0;
        AMosi = '0;
        AWrEn = '0;
        ARdEn = 1'b0;
        unique case (state_q)
            ST_RD: begin
                AAddr = src;
                ARdEn = 1'b1;
            end
            ST_WR: begin
                AAddr = dst;
                AWrEn = '1;
                AMosi = fill_q ? fill_data : AMiso;
            end
            ST_IDLE, ST_DONE: begin
                AAddr = '0;
            end
        endcase
    end

    assign ABusy = busy_q;
    assign ADone = done_q;
    assign ACnt  = cnt;

endmodule

// File: tb/tb_mem_copy_mst.sv
// Self-checking bench for mem_copy_mst with a behavioural RAM slave.
// Define MEM_COPY_FILL_EN to also exercise fill mode.
module tb_mem_copy_mst;
    import mem_copy_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src = '0;
    logic [AW-1:0] dst = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, rden;
    logic [AW:0]   cnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] mosi, miso, wren;
`ifdef MEM_COPY_FILL_EN
    logic          fill = 1'b0;
    logic [DW-1:0] fill_data = '0;
`endif

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] ref_mem [256];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    logic [DW-1:0] rd_q = '0;

    logic [AW+DW-1:0] exp_q [$];
    logic [AW+DW-1:0] obs_w [1024];
    logic [AW-1:0]    obs_r [1024];
    int obs_n = 0;
    int rd_n = 0;
    int done_n = 0;
    int wr_ptr = 0;

    always #5 clk = ~clk;

    mem_copy_mst dut (
        .AClkH    (clk),
        .AResetN  (rst_n),
        .AClkHEn  (en),
        .AStart   (start),
        .AAbort   (abort),
        .ASrc     (src),
        .ADst     (dst),
        .ALen     (len),
`ifdef MEM_COPY_FILL_EN
        .AFill    (fill),
        .AFillData(fill_data),
`endif
        .ABusy    (busy),
        .ADone    (done),
        .ACnt     (cnt),
        .AAddr    (addr),
        .AMosi    (mosi),
        .AMiso    (miso),
        .AWrEn    (wren),
        .ARdEn    (rden)
    );

    assign miso = rd_q;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (en) begin
            if (rden) rd_q <= mem[addr];
            if (|wren) mem[addr] <= (mem[addr] & ~wren) | (mosi & wren);
        end
    end

    always @(negedge clk) begin
        if (en) begin
            if (|wren) begin
                obs_w[obs_n] <= {addr, mosi};
                obs_n <= obs_n + 1;
            end
            if (rden) begin
                obs_r[rd_n] <= addr;
                rd_n <= rd_n + 1;
            end
            if (done) done_n <= done_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = v;
        step();
        pl_en = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
        logic [AW-1:0] sa, da;
        logic [DW-1:0] v;
        for (int i = 0; i < n; i++) begin
            sa = s + AW'(i);
            da = d + AW'(i);
            v = ref_mem[sa];
            ref_mem[da] = v;
            exp_q.push_back({da, v});
        end
    endtask

    task automatic start_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] l);
        src = s;
        dst = d;
        len = l;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int n);
        int k;
        bit e;
        n = 0;
        k = 0;
        while (done !== 1'b1 && k < maxc) begin
            e = en;
            step();
            if (e) n++;
            k++;
        end
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, obs_n - wr_ptr, exp_q.size());
        while (exp_q.size() > 0 && wr_ptr < obs_n) begin
            chk(tag, obs_w[wr_ptr], exp_q.pop_front());
            wr_ptr++;
        end
        exp_q.delete();
        wr_ptr = obs_n;
    endtask

    initial begin
        int n;
        int k;
        int rd0;
        int d0;
        bit e;

        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_addr", addr, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_wren", wren, 0);
        chk("rst_rden", rden, 0);
        rst_n = 1'b1;
        step();

        // basic 4-word copy
        for (int i = 0; i < 4; i++) preload(AW'(8'h10 + i), DW'(16'h00A1 + i));
        model_copy(8'h10, 8'h80, 4);
        start_copy(8'h10, 8'h80, 4);
        chk("t1_rd", rden, 1);
        chk("t1_addr", addr, 8'h10);
        wait_done(50, n);
        chk("t1_lat", n, 8);
        chk("t1_cnt", cnt, 4);
        chk("t1_busy", busy, 1);
        step();
        chk("t1_done_off", done, 0);
        chk("t1_idle", busy, 0);
        chk("t1_cnt_hold", cnt, 4);
        check_writes("t1_wr");
        chk("t1_mem", mem[8'h83], 16'h00A4);

        // zero length
        rd0 = rd_n;
        start_copy(8'h30, 8'h31, 0);
        chk("t2_done", done, 1);
        chk("t2_cnt", cnt, 0);
        step();
        chk("t2_done_off", done, 0);
        chk("t2_nrd", rd_n - rd0, 0);
        check_writes("t2_wr");

        // address wrap with forward overlap
        preload(8'hFE, 16'hBEEF);
        preload(8'hFF, 16'hCAFE);
        preload(8'h00, 16'hF00D);
        rd0 = rd_n;
        model_copy(8'hFE, 8'h00, 3);
        start_copy(8'hFE, 8'h00, 3);
        wait_done(50, n);
        chk("t3_lat", n, 6);
        chk("t3_nrd", rd_n - rd0, 3);
        chk("t3_rd0", obs_r[rd0], 8'hFE);
        chk("t3_rd1", obs_r[rd0 + 1], 8'hFF);
        chk("t3_rd2", obs_r[rd0 + 2], 8'h00);
        step();
        check_writes("t3_wr");

        // abort during write of word 2
        for (int i = 0; i < 5; i++) preload(AW'(8'h40 + i), DW'(16'h4000 + i));
        model_copy(8'h40, 8'h60, 2);
        d0 = done_n;
        start_copy(8'h40, 8'h60, 5);
        step();
        step();
        step();
        chk("t4_wr_state", wren, 16'hFFFF);
        chk("t4_wr_addr", addr, 8'h61);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_done", done, 1);
        chk("t4_cnt", cnt, 2);
        step();
        chk("t4_idle", busy, 0);
        chk("t4_ndone", done_n - d0, 1);
        check_writes("t4_wr");

        // abort during read of word 3
        model_copy(8'h40, 8'h68, 2);
        start_copy(8'h40, 8'h68, 5);
        for (int i = 0; i < 4; i++) step();
        chk("t5_rd_state", rden, 1);
        chk("t5_rd_addr", addr, 8'h42);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_done", done, 1);
        chk("t5_cnt", cnt, 2);
        step();
        check_writes("t5_wr");

        // clock enable toggling
        for (int i = 0; i < 3; i++) preload(AW'(8'h50 + i), DW'(16'h5A00 + i));
        model_copy(8'h50, 8'h90, 3);
        start_copy(8'h50, 8'h90, 3);
        en = 1'b0;
        step();
        chk("t6_hold_rd", rden, 1);
        chk("t6_hold_addr", addr, 8'h50);
        n = 0;
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            en = ~en;
            e = en;
            step();
            if (e) n++;
            k++;
        end
        chk("t6_lat", n, 6);
        en = 1'b0;
        step();
        chk("t6_done_held", done, 1);
        en = 1'b1;
        step();
        chk("t6_done_off", done, 0);
        chk("t6_cnt", cnt, 3);
        check_writes("t6_wr");

        // reset mid-copy, ignoring clock enable
        for (int i = 0; i < 4; i++) preload(AW'(8'hA0 + i), 16'h5555);
        model_copy(8'h10, 8'hA0, 1);
        start_copy(8'h10, 8'hA0, 4);
        step();
        step();
        rst_n = 1'b0;
        en = 1'b0;
        step();
        rst_n = 1'b1;
        en = 1'b1;
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_cnt", cnt, 0);
        chk("t7_addr", addr, 0);
        chk("t7_wren", wren, 0);
        chk("t7_rden", rden, 0);
        step();
        check_writes("t7_wr");
        for (int i = 1; i < 4; i++) begin
            chk("t7_untouched", mem[AW'(8'hA0 + i)], 16'h5555);
        end

`ifdef MEM_COPY_FILL_EN
        // constant fill
        fill = 1'b1;
        fill_data = 16'hA5A5;
        for (int i = 0; i < 8; i++) begin
            ref_mem[AW'(8'h20 + i)] = 16'hA5A5;
            exp_q.push_back({AW'(8'h20 + i), 16'hA5A5});
        end
        rd0 = rd_n;
        start_copy(8'h00, 8'h20, 8);
        fill = 1'b0;
        wait_done(50, n);
        chk("t8_lat", n, 8);
        chk("t8_nrd", rd_n - rd0, 0);
        chk("t8_cnt", cnt, 8);
        step();
        check_writes("t8_wr");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
